// File: rtl/debounce_pkg.sv
//------------------------------------------------------------------------------
// Module   : debounce_pkg
// Brief    : Shared state encoding and counter sizing for the switch debouncer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t STABLE_LO = 2'd0;
    localparam state_t WAIT_HI   = 2'd1;
    localparam state_t STABLE_HI = 2'd2;
    localparam state_t WAIT_LO   = 2'd3;

    // ceil(log2(cycles)), never narrower than one bit
    function automatic int cnt_width(input int cycles);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(cycles)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
//------------------------------------------------------------------------------
// Module   : debounce_bit
// Brief    : One switch channel: 2-flop synchronizer, hold counter, FSM, pulses.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int              C_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [C_CNT_W-1:0] r_cnt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_clean;
    logic               r_rise;
    logic               r_fall;
    logic               w_clean_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;
    logic               w_cnt_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cnt_done = (r_cnt == C_CNT_LAST);

    // Counts only while the synchronized level disagrees; acceptance clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_sync2 != r_clean) && !w_cnt_done) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STABLE_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STABLE_LO: if (r_sync2) w_state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (!r_sync2)        w_state_nxt = STABLE_LO;
                else if (w_cnt_done) w_state_nxt = STABLE_HI;
            end
            STABLE_HI: if (!r_sync2) w_state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (r_sync2)         w_state_nxt = STABLE_HI;
                else if (w_cnt_done) w_state_nxt = STABLE_LO;
            end
            default: w_state_nxt = STABLE_LO;
        endcase
    end

    always_comb begin
        w_clean_nxt = r_clean;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if ((r_state == WAIT_HI) && (w_state_nxt == STABLE_HI)) begin
            w_clean_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
        end
        if ((r_state == WAIT_LO) && (w_state_nxt == STABLE_LO)) begin
            w_clean_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign sw_clean = r_clean;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
//------------------------------------------------------------------------------
// Module   : switch_debounce
// Brief    : N independent debounced switch channels with a shared change flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module switch_debounce
    import debounce_pkg::*;
#(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_clean,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed
);

    generate
        for (genvar g = 0; g < N; g++) begin : g_chan
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .reset   (reset),
                .sw_raw  (sw_raw[g]),
                .sw_clean(sw_clean[g]),
                .sw_rise (sw_rise[g]),
                .sw_fall (sw_fall[g])
            );
        end
    endgenerate

    // Pulses are already registered, so this OR adds no path from sw_raw
    assign sw_changed = |(sw_rise | sw_fall);

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
//------------------------------------------------------------------------------
// Module   : tb_switch_debounce
// Brief    : Randomized and directed bench for switch_debounce with a window model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_switch_debounce;

    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_clean;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_changed;

    always #5 clk = ~clk;

    switch_debounce #(
        .N              (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    int checks = 0;
    int passes = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: raw samples per edge; the synchronized level seen at an edge is the
    // raw level sampled two edges earlier. A level is accepted once it has been
    // seen for D consecutive edges while differing from the accepted level.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_clean = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;

    function automatic logic s2(input int j, input int c);
        int idx;
        idx = 2 + j;
        if (idx < hist.size()) return hist[idx][c];
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [N-1:0] nc, nr, nf;
        logic v, same;
        if (reset) begin
            hist.delete();
            m_clean <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
        end else begin
            hist.push_front(sw_raw);
            if (hist.size() > D + 2) void'(hist.pop_back());
            nc = m_clean;
            nr = '0;
            nf = '0;
            for (int c = 0; c < N; c++) begin
                v = s2(0, c);
                same = 1'b1;
                for (int j = 1; j < D; j++) if (s2(j, c) != v) same = 1'b0;
                if (same && (v != m_clean[c])) begin
                    nc[c] = v;
                    if (v) nr[c] = 1'b1;
                    else   nf[c] = 1'b1;
                end
            end
            m_clean <= nc;
            m_rise  <= nr;
            m_fall  <= nf;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_clean",   sw_clean,   m_clean);
            chk("cmp_rise",    sw_rise,    m_rise);
            chk("cmp_fall",    sw_fall,    m_fall);
            chk("cmp_changed", sw_changed, |(m_rise | m_fall));
        end
    end

    initial begin
        int g, nrise, at;
        int len [N];

        reset  = 1'b1;
        sw_raw = '0;
        repeat (3) @(negedge clk);
        chk("rst_clean",   sw_clean,   0);
        chk("rst_rise",    sw_rise,    0);
        chk("rst_changed", sw_changed, 0);
        cmp_en = 1'b1;

        // Clean step on channel 0
        reset  = 1'b0;
        sw_raw = 2'b01;
        repeat (5) @(negedge clk);
        chk("step_e5_clean", sw_clean, 2'b00);
        @(negedge clk);
        chk("step_e6_clean",   sw_clean,   2'b01);
        chk("step_e6_rise",    sw_rise,    2'b01);
        chk("step_e6_changed", sw_changed, 1);
        @(negedge clk);
        chk("step_e7_rise",    sw_rise,    2'b00);
        chk("step_e7_changed", sw_changed, 0);

        // Three-cycle glitch on channel 1
        sw_raw = 2'b11;
        repeat (3) @(negedge clk);
        sw_raw = 2'b01;
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (sw_rise[1] || sw_fall[1] || sw_clean[1]) g++;
        end
        chk("glitch_activity", g, 0);

        // Bounce then settle on channel 0
        sw_raw = 2'b00;
        repeat (8) @(negedge clk);
        nrise = 0;
        at    = -1;
        for (int i = 0; i < 5; i++) begin
            sw_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (sw_rise[0]) nrise++;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sw_rise[0]) begin
                nrise++;
                if (at < 0) at = k;
            end
        end
        chk("bounce_rises", nrise, 1);
        chk("bounce_edge",  at,    5);

        // Simultaneous rise on both channels
        sw_raw = 2'b00;
        repeat (8) @(negedge clk);
        sw_raw = 2'b11;
        repeat (5) @(negedge clk);
        chk("simul_e5_clean", sw_clean, 2'b00);
        @(negedge clk);
        chk("simul_e6_clean",   sw_clean,   2'b11);
        chk("simul_e6_rise",    sw_rise,    2'b11);
        chk("simul_e6_changed", sw_changed, 1);
        @(negedge clk);
        chk("simul_e7_rise", sw_rise, 2'b00);

        // Asynchronous reset in the middle of a WAIT_HI count
        sw_raw = 2'b10;
        repeat (8) @(negedge clk);
        sw_raw = 2'b11;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_clean",   sw_clean,   2'b00);
        chk("rstmid_rise",    sw_rise,    2'b00);
        chk("rstmid_changed", sw_changed, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstrel_e5_clean", sw_clean, 2'b00);
        @(negedge clk);
        chk("rstrel_e6_clean", sw_clean, 2'b11);
        chk("rstrel_e6_rise",  sw_rise,  2'b11);

        // Falling edge from sw_clean = 2'b10
        sw_raw = 2'b10;
        repeat (8) @(negedge clk);
        chk("fall_pre_clean", sw_clean, 2'b10);
        sw_raw = 2'b00;
        repeat (5) @(negedge clk);
        chk("fall_e5_fall", sw_fall, 2'b00);
        @(negedge clk);
        chk("fall_e6_fall",  sw_fall,  2'b10);
        chk("fall_e6_clean", sw_clean, 2'b00);
        @(negedge clk);
        chk("fall_e7_fall", sw_fall, 2'b00);

        // Random runs of varying length, with one short async reset pulse
        for (int c = 0; c < N; c++) len[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (len[c] == 0) begin
                    sw_raw[c] = 1'($urandom_range(0, 1));
                    len[c]    = int'($urandom_range(1, 2 * D + 2));
                end
                len[c]--;
            end
            if (cyc == 1500) begin
                #2 reset = 1'b1;
                #1;
                chk("rand_rst_clean", sw_clean, 0);
                #1 reset = 1'b0;
            end
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
